// File: rtl/tt_ha_serial_pkg.sv
// Shared definitions for the bit-serial adder controller.
//   state_t   : controller state encoding (IDLE / RUN / DONE)
//   WIDTH_DEF : default operand width in bits
//   CNT_W     : width of the bit counter that walks the operand bits
package tt_ha_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_DEF = 4;
    localparam int CNT_W     = $clog2(WIDTH_DEF);

endpackage

// File: rtl/ha_cell.sv
// Half-adder cell. Two of these plus an OR form one full-add bit.
//   a, b : input bits
//   s    : sum bit   (a ^ b)
//   c    : carry bit (a & b)
module ha_cell (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/tt_um_ha_serial_ctrl.sv
// Bit-serial adder controller. One shared full-add bit processes the
// operands LSB first, one bit per enabled clock.
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset
//   ena     : design enable; all state holds while low
//   ui_in   : [3:0] operand A, [7:4] operand B
//   uio_in  : [0] start (level), [1] carry-in, [7:2] unused
//   uo_out  : [3:0] sum, [4] cout, [5] busy, [6] done, [7] 0
//   uio_out : tied 0
//   uio_oe  : tied 0 (all uio pins are inputs)
//
// state | meaning
// IDLE  | waiting for start; latches operands when start seen
// RUN   | one operand bit added per enabled cycle, LSB first
// DONE  | result valid and done asserted for one cycle
module tt_um_ha_serial_ctrl
    import tt_ha_serial_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   a_sh, b_sh, res_sh, sum_q;
    logic               carry_q, cout_q;

    logic start, cin, last_bit;
    logic p_bit, g_bit, s_bit, pc_bit, c_next;
    logic unused_ok;

    assign start    = uio_in[0];
    assign cin      = uio_in[1];
    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));
    assign unused_ok = &{1'b0, uio_in[7:2]};

    // Full-add bit: propagate/generate from the operand bits, then fold
    // in the running carry.
    ha_cell u_ha0 (.a(a_sh[0]), .b(b_sh[0]), .s(p_bit), .c(g_bit));
    ha_cell u_ha1 (.a(p_bit),   .b(carry_q), .s(s_bit), .c(pc_bit));
    assign c_next = g_bit | pc_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else if (ena) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_bit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            a_sh    <= '0;
            b_sh    <= '0;
            res_sh  <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else if (ena) begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_sh    <= ui_in[WIDTH-1:0];
                        b_sh    <= ui_in[4 +: WIDTH];
                        carry_q <= cin;
                        cnt_q   <= '0;
                    end
                end
                RUN: begin
                    // Sum bits enter at the MSB so that after WIDTH shifts
                    // the first (LSB) result bit sits at position 0.
                    res_sh  <= {s_bit, res_sh[WIDTH-1:1]};
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    carry_q <= c_next;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (last_bit) begin
                        sum_q  <= {s_bit, res_sh[WIDTH-1:1]};
                        cout_q <= c_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign uo_out  = {1'b0, (state_q == DONE), (state_q == RUN), cout_q, sum_q};
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule
